// File: rtl/md_issue_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_issue_stage_pkg
// Description : Shared opcode/funct encodings for the multiply/divide path
//               and the execute-slot record used by the issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
package md_issue_stage_pkg;

  localparam int unsigned XLEN = 32;

  // Opcode and funct encodings, also used by the multiply/divide unit
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] FN_MULT    = 6'b011000;
  localparam logic [5:0] FN_MULTU   = 6'b011001;
  localparam logic [5:0] FN_DIV     = 6'b011010;
  localparam logic [5:0] FN_DIVU    = 6'b011011;
  localparam logic [5:0] FN_MFHI    = 6'b010000;
  localparam logic [5:0] FN_MTHI    = 6'b010001;
  localparam logic [5:0] FN_MFLO    = 6'b010010;
  localparam logic [5:0] FN_MTLO    = 6'b010011;

  // sll $0,$0,0 -- the canonical nop; never decodes as an MD instruction
  localparam logic [XLEN-1:0] NOP_INSTR = '0;

  // Contents of the execute-stage register
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic            valid;
  } e_slot_t;

endpackage : md_issue_stage_pkg
`default_nettype wire

// File: rtl/md_issue_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : md_issue_stage_if
// Description : Decode-side inputs, MD-unit status, and execute-side outputs
//               of the issue stage. The slave modport is the stage itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface md_issue_stage_if;
  import md_issue_stage_pkg::*;

  logic [XLEN-1:0] d_instr;
  logic [XLEN-1:0] d_pc;
  logic [XLEN-1:0] d_rs_data;
  logic [XLEN-1:0] d_rt_data;
  logic            d_valid;
  logic            ext_stall;
  logic            md_start;
  logic            md_busy;

  logic [XLEN-1:0] e_instr;
  logic [XLEN-1:0] e_pc;
  logic [XLEN-1:0] e_rs_data;
  logic [XLEN-1:0] e_rt_data;
  logic            e_valid;
  logic            d_stall;
  logic [XLEN-1:0] md_stall_cnt;

  // Surrounding pipeline / MD unit side
  modport master (
    output d_instr, d_pc, d_rs_data, d_rt_data, d_valid,
    output ext_stall, md_start, md_busy,
    input  e_instr, e_pc, e_rs_data, e_rt_data, e_valid,
    input  d_stall, md_stall_cnt
  );

  // Issue stage side
  modport slave (
    input  d_instr, d_pc, d_rs_data, d_rt_data, d_valid,
    input  ext_stall, md_start, md_busy,
    output e_instr, e_pc, e_rs_data, e_rt_data, e_valid,
    output d_stall, md_stall_cnt
  );

endinterface : md_issue_stage_if
`default_nettype wire

// File: rtl/md_issue_stage_md_decode.sv
`default_nettype none
// ============================================================================
// Module      : md_decode
// Description : Flags instructions that use the multiply/divide unit or the
//               HI/LO registers. Purely combinational; shared with the
//               hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
module md_decode
  import md_issue_stage_pkg::*;
(
  input  wire logic [XLEN-1:0] i_instr,
  output logic                 o_is_md
);

  logic [5:0] w_opcode;
  logic [5:0] w_funct;

  assign w_opcode = i_instr[31:26];
  assign w_funct  = i_instr[5:0];

  // SPECIAL-opcode instructions whose funct selects the MD unit or HI/LO
  always_comb begin
    o_is_md = 1'b0;
    if (w_opcode == OP_SPECIAL) begin
      case (w_funct)
        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
        FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO: o_is_md = 1'b1;
        default:                            o_is_md = 1'b0;
      endcase
    end
  end

endmodule : md_decode
`default_nettype wire

// File: rtl/md_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : md_issue_stage
// Description : D->E issue register with multiply/divide structural hazard
//               detection. Holds MD instructions in decode while the MD unit
//               is starting or busy, inserts nop bubbles into execute, and
//               counts MD-induced stall cycles (saturating).
// Revision    : 1.0 - initial release
// ============================================================================
module md_issue_stage
  import md_issue_stage_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        reset,
  md_issue_stage_if.slave  bus
);

  logic        w_d_is_md;
  logic        w_md_hazard;
  logic        w_d_stall;
  e_slot_t     r_e_slot;
  logic [XLEN-1:0] r_md_stall_cnt;

  md_decode u_md_decode (
    .i_instr (bus.d_instr),
    .o_is_md (w_d_is_md)
  );

  // An MD instruction may not issue while the unit is starting (the E
  // instruction is launching it this cycle) or still busy
  assign w_md_hazard = bus.d_valid & w_d_is_md & (bus.md_start | bus.md_busy);
  assign w_d_stall   = w_md_hazard | bus.ext_stall;

  // Execute register: load from decode, or inject a nop bubble on stall.
  // The bubble carries the decode PC so E always has a meaningful PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_e_slot <= '0;
    end else if (w_d_stall) begin
      r_e_slot.instr   <= NOP_INSTR;
      r_e_slot.pc      <= bus.d_pc;
      r_e_slot.rs_data <= '0;
      r_e_slot.rt_data <= '0;
      r_e_slot.valid   <= 1'b0;
    end else begin
      r_e_slot.instr   <= bus.d_instr;
      r_e_slot.pc      <= bus.d_pc;
      r_e_slot.rs_data <= bus.d_rs_data;
      r_e_slot.rt_data <= bus.d_rt_data;
      r_e_slot.valid   <= bus.d_valid;
    end
  end

  // Count cycles lost to the MD unit only; saturates at all-ones
  always_ff @(posedge clk) begin
    if (reset) begin
      r_md_stall_cnt <= '0;
    end else if (w_md_hazard && (r_md_stall_cnt != '1)) begin
      r_md_stall_cnt <= r_md_stall_cnt + 1'b1;
    end
  end

  assign bus.e_instr      = r_e_slot.instr;
  assign bus.e_pc         = r_e_slot.pc;
  assign bus.e_rs_data    = r_e_slot.rs_data;
  assign bus.e_rt_data    = r_e_slot.rt_data;
  assign bus.e_valid      = r_e_slot.valid;
  assign bus.d_stall      = w_d_stall;
  assign bus.md_stall_cnt = r_md_stall_cnt;

endmodule : md_issue_stage
`default_nettype wire

// File: tb/tb_md_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_issue_stage
// Description : Directed self-checking bench for md_issue_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_issue_stage;

  localparam logic [31:0] C_MULT = 32'h0085_0018;
  localparam logic [31:0] C_MFHI = 32'h0000_1010;
  localparam logic [31:0] C_ADDU = 32'h0085_1021;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;
  logic [31:0] exp_cnt;

  md_issue_stage_if bus ();

  md_issue_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs, input logic [31:0] rt, input logic valid);
    bus.d_instr   = instr;
    bus.d_pc      = pc;
    bus.d_rs_data = rs;
    bus.d_rt_data = rt;
    bus.d_valid   = valid;
  endtask

  task automatic check_bubble(input string tag, input logic [31:0] pc);
    check({tag, " e_instr"},   bus.e_instr, 32'h0);
    check({tag, " e_valid"},   {31'b0, bus.e_valid}, 32'h0);
    check({tag, " e_rs_data"}, bus.e_rs_data, 32'h0);
    check({tag, " e_pc"},      bus.e_pc, pc);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    exp_cnt  = 0;
    reset    = 1'b1;
    bus.ext_stall = 1'b0;
    bus.md_start  = 1'b0;
    bus.md_busy   = 1'b0;
    set_d(C_ADDU, 32'h0000_0400, 32'hAAAA_0001, 32'hBBBB_0002, 1'b1);
    step();
    step();

    // Reset state; d_stall remains combinational while in reset
    check("rst e_instr", bus.e_instr, 32'h0);
    check("rst e_pc", bus.e_pc, 32'h0);
    check("rst e_rt_data", bus.e_rt_data, 32'h0);
    check("rst e_valid", {31'b0, bus.e_valid}, 32'h0);
    check("rst cnt", bus.md_stall_cnt, 32'h0);
    set_d(C_MULT, 32'h0000_0400, 32'h0, 32'h0, 1'b1);
    bus.md_start = 1'b1;
    #1;
    check("rst d_stall comb", {31'b0, bus.d_stall}, 32'h1);
    bus.md_start = 1'b0;
    step();
    reset = 1'b0;

    // mult with no hazard issues directly
    set_d(C_MULT, 32'h0000_1000, 32'h0000_0007, 32'h0000_0009, 1'b1);
    #1;
    check("mult d_stall", {31'b0, bus.d_stall}, 32'h0);
    step();
    check("mult e_instr", bus.e_instr, C_MULT);
    check("mult e_pc", bus.e_pc, 32'h0000_1000);
    check("mult e_rs", bus.e_rs_data, 32'h0000_0007);
    check("mult e_rt", bus.e_rt_data, 32'h0000_0009);
    check("mult e_valid", {31'b0, bus.e_valid}, 32'h1);

    // mfhi waits behind md_start then 5 busy cycles
    set_d(C_MFHI, 32'h0000_1004, 32'h1, 32'h2, 1'b1);
    bus.md_start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) begin
        bus.md_start = 1'b0;
        bus.md_busy  = 1'b1;
      end
      #1;
      check($sformatf("mfhi d_stall %0d", i), {31'b0, bus.d_stall}, 32'h1);
      step();
      exp_cnt++;
      check_bubble($sformatf("mfhi bubble %0d", i), 32'h0000_1004);
    end
    check("mfhi cnt", bus.md_stall_cnt, 32'd6);
    bus.md_busy = 1'b0;
    #1;
    check("mfhi release d_stall", {31'b0, bus.d_stall}, 32'h0);
    step();
    check("mfhi e_instr", bus.e_instr, C_MFHI);
    check("mfhi e_valid", {31'b0, bus.e_valid}, 32'h1);

    // non-MD instruction passes while the unit is busy
    bus.md_busy = 1'b1;
    set_d(C_ADDU, 32'h0000_1008, 32'h0000_0033, 32'h0000_0044, 1'b1);
    #1;
    check("addu d_stall", {31'b0, bus.d_stall}, 32'h0);
    step();
    check("addu e_instr", bus.e_instr, C_ADDU);
    check("addu e_rt", bus.e_rt_data, 32'h0000_0044);
    check("addu cnt", bus.md_stall_cnt, exp_cnt);

    // invalid MD slot while busy: no hazard, no count
    set_d(C_MFHI, 32'h0000_100C, 32'h5, 32'h6, 1'b0);
    #1;
    check("inv d_stall", {31'b0, bus.d_stall}, 32'h0);
    step();
    check("inv e_valid", {31'b0, bus.e_valid}, 32'h0);
    check("inv cnt", bus.md_stall_cnt, exp_cnt);

    // 3 cycles of ext_stall+hazard, then 2 of ext_stall alone
    set_d(C_MFHI, 32'h0000_1010, 32'h5, 32'h6, 1'b1);
    bus.ext_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) bus.md_busy = 1'b0;
      #1;
      check($sformatf("ext d_stall %0d", i), {31'b0, bus.d_stall}, 32'h1);
      step();
      if (i < 3) exp_cnt++;
      check_bubble($sformatf("ext bubble %0d", i), 32'h0000_1010);
    end
    check("ext cnt", bus.md_stall_cnt, 32'd9);
    bus.ext_stall = 1'b0;

    // reset asserted in the middle of an MD stall
    bus.md_busy = 1'b1;
    step();
    check("pre-rst cnt", bus.md_stall_cnt, 32'd10);
    reset = 1'b1;
    step();
    check("midrst e_instr", bus.e_instr, 32'h0);
    check("midrst e_pc", bus.e_pc, 32'h0);
    check("midrst e_rs", bus.e_rs_data, 32'h0);
    check("midrst e_valid", {31'b0, bus.e_valid}, 32'h0);
    check("midrst cnt", bus.md_stall_cnt, 32'h0);
    reset = 1'b0;

    // saturation: preset near the top, hold the hazard 3 cycles
    force dut.r_md_stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_md_stall_cnt;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("sat cnt %0d", i), bus.md_stall_cnt, 32'hFFFF_FFFF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1);
  end

endmodule : tb_md_issue_stage
`default_nettype wire
